// File: rtl/data_scrambler_tx.sv
// Transmit-side 32-bit LFSR scrambler. Frames from a valid/ready/last stream leave as one
// registered word per clock; idle words with scr_en=0 separate frames so the far end re-seeds.
module data_scrambler_tx #(
  parameter logic [15:0] P_INIT_VALID = 16'h76d8,
  parameter logic [31:0] P_IDLE_DATA  = 32'h0,
  parameter logic [3:0]  P_IDLE_CHAR  = 4'h0,
  parameter int unsigned P_GAP_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_char,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [31:0] o_scr_data,
  output logic [3:0]  o_scr_char,
  output logic        o_scr_en,
  output logic        o_underrun,
  output logic [15:0] o_frame_cnt
);

  localparam logic [7:0] LP_GAP_LAST = 8'(P_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  w_gap_cnt_next;
  logic [15:0] r_seed;
  logic [31:0] r_scr_data;
  logic [3:0]  r_scr_char;
  logic        r_scr_en;
  logic        r_underrun;
  logic [15:0] r_frame_cnt;
  logic        w_accept;
  logic        w_underrun_next;
  logic        w_frame_done;
  logic [47:0] w_lfsr;

  // Ready depends only on registered state and reset, never on i_valid.
  assign o_ready  = i_rst_n & (r_state != ST_GAP);
  assign w_accept = i_valid & o_ready;

  // Full 32-step unroll: keystream is w_lfsr[31:0], the following seed is w_lfsr[47:32].
  always_comb begin
    w_lfsr        = '0;
    w_lfsr[15:0]  = r_seed;
    for (int i = 0; i < 32; i++) begin
      w_lfsr[16+i] = w_lfsr[i] ^ w_lfsr[i+4] ^ w_lfsr[i+13] ^ w_lfsr[i+15];
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_gap_cnt_next  = r_gap_cnt;
    w_underrun_next = 1'b0;
    w_frame_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (i_last) begin
            w_state_next   = ST_GAP;
            w_gap_cnt_next = 8'd0;
            w_frame_done   = 1'b1;
          end else begin
            w_state_next = ST_FRAME;
          end
        end
      end
      ST_FRAME: begin
        if (w_accept) begin
          if (i_last) begin
            w_state_next   = ST_GAP;
            w_gap_cnt_next = 8'd0;
            w_frame_done   = 1'b1;
          end
        end else begin
          // A bubble mid-frame aborts the frame rather than being filled with scrambled padding.
          w_underrun_next = 1'b1;
          w_state_next    = ST_GAP;
          w_gap_cnt_next  = 8'd0;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == LP_GAP_LAST) begin
          w_state_next   = ST_IDLE;
          w_gap_cnt_next = 8'd0;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_gap_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_gap_cnt   <= 8'd0;
      r_seed      <= P_INIT_VALID;
      r_scr_data  <= 32'd0;
      r_scr_char  <= 4'd0;
      r_scr_en    <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_underrun <= w_underrun_next;
      if (w_accept) begin
        r_scr_data <= i_data ^ w_lfsr[31:0];
        r_scr_char <= i_char;
        r_scr_en   <= 1'b1;
        r_seed     <= w_lfsr[47:32];
      end else begin
        r_scr_data <= P_IDLE_DATA;
        r_scr_char <= P_IDLE_CHAR;
        r_scr_en   <= 1'b0;
        r_seed     <= P_INIT_VALID;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign o_scr_data  = r_scr_data;
  assign o_scr_char  = r_scr_char;
  assign o_scr_en    = r_scr_en;
  assign o_underrun  = r_underrun;
  assign o_frame_cnt = r_frame_cnt;

endmodule
